inv_key_schedule: RTL and testbench
===================================

# inv_key_schedule

- Generates AES-128 round keys in reverse order (K10 down to K0) for the decryption datapath.
- Works as the mirror of the forward key expansion. On a load request it expands the cipher key forward to K10, one round per cycle.
- It then walks backwards one round key per request, using the inverse key-schedule recurrence. No 11-entry key store is needed.
- It sits between the key input register and the inverse-round datapath. The inverse round controller drives `pi_next_key` once per decryption round.

## Interface
- No parameters.
- `pi_clk` input 1: clock. All state updates on the rising edge.
- `pi_rst` input 1: reset, asynchronous, active-high.
- `pi_input_key` input 128: cipher key K0. Sampled only on an accepted `pi_load`.
- `pi_load` input 1: start request. Accepted in IDLE or OUTPUT, ignored in EXPAND.
- `pi_next_key` input 1: advance request. Only acted on in OUTPUT.
- `po_round_key` output 128: current round key. Byte 0 is [127:120]; word w0 is [127:96].
- `po_round_idx` output 4: index of the round key on `po_round_key`, range 0..10.
- `po_key_valid` output 1: high while `po_round_key` and `po_round_idx` are valid (state OUTPUT).
- `po_busy` output 1: high in state EXPAND.

## Operation
- Registers:
  - `key_r` [127:0], `round_r` [3:0].
  - state is one of IDLE, EXPAND, OUTPUT.
  - `po_round_key` comes from `key_r`, passed through InvMixColumns when enabled (see Configuration).
  - `po_round_idx` = `round_r`.
- Rcon for round r (1..10): 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, placed in byte [31:24] with [23:0] = 0.
- g(x) = SubWord(RotWord(x)), where RotWord(x) = {x[23:0], x[31:24]}.
  - A single 4-byte S-box instance computes g.
  - Its input is muxed: w3 in EXPAND, w3^w2 in OUTPUT.
- Forward step, r-1 -> r:
  - n0 = w0 ^ g(w3) ^ rcon_r
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
- Inverse step, r -> r-1:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ g(p3) ^ rcon_r
- All XORs are 32-bit, bitwise, with no carries.
- FSM:
  - IDLE: on `pi_load`, `key_r` <= `pi_input_key`, `round_r` <= 0, go to EXPAND.
  - EXPAND:
    - Each cycle, `key_r` <= forward(`key_r`, rcon of `round_r`+1) and `round_r` <= `round_r`+1.
    - On the step that makes `round_r` = 10, go to OUTPUT.
    - `pi_load` and `pi_next_key` are ignored.
  - OUTPUT, evaluated in this priority order:
    1. `pi_load`: restart exactly as from IDLE. This wins over `pi_next_key`.
    2. `pi_next_key` with `round_r` > 0: `key_r` <= inverse(`key_r`, rcon of `round_r`), `round_r` <= `round_r`-1, stay in OUTPUT.
    3. `pi_next_key` with `round_r` = 0: go to IDLE. `key_r` and `round_r` hold their values.
- `po_key_valid` = (state == OUTPUT). `po_busy` = (state == EXPAND).
- Reset, including mid-EXPAND or mid-OUTPUT: state IDLE; `key_r`, `round_r`, `po_round_key`, `po_round_idx`, `po_key_valid`, `po_busy` all 0. Any operation in progress is abandoned.
- `round_r` never leaves 0..10, and `round_r` = 0 with `pi_next_key` never wraps.

## Timing
- `pi_load` is sampled at edge E0.
- EXPAND spans edges E1..E10. `po_busy` is high from after E0 until E10.
- After E10: `po_key_valid` = 1, `po_round_idx` = 10, `po_round_key` = K10. Load-to-first-key latency is 10 cycles.
- Each accepted `pi_next_key` updates key and index at the same edge. One key per cycle with back-to-back requests; K0 appears 10 requests after K10.
- `pi_next_key` held high continuously steps through K9..K0 on consecutive cycles. The 11th request drops `po_key_valid` at that edge.
- InvMixColumns, when compiled in, is combinational on the output path and adds no latency.

## Configuration
- Macro: `INV_KEY_MIXCOL_EN`.
- Defined (for the equivalent inverse cipher):
  - `po_round_key` = InvMixColumns(`key_r`) for `round_r` in 1..9.
  - Each column uses GF(2^8) coefficients 0e, 0b, 0d, 09 with polynomial 11b.
  - For `round_r` 0 and 10, `po_round_key` = `key_r` unmodified.
  - The internal recurrence always operates on raw keys.
- Undefined: `po_round_key` = `key_r` for every round, and no InvMixColumns logic is present.

## Test plan
- Reset check: assert `pi_rst` with random inputs -> all outputs 0 and state IDLE. Then `pi_next_key` = 1 with no load -> outputs stay 0.
- FIPS-197 vector, `pi_input_key` = 2b7e151628aed2a6abf7158809cf4f3c, `pi_load` pulse:
  - `po_busy` high for exactly 10 cycles.
  - Then `po_key_valid` = 1, idx 10, key d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same vector, then `pi_next_key` held high (macro undefined):
  - Idx 9 shows ac7766f319fadc2128d12941575c006e.
  - Idx 1 shows a0fafe1788542cb123a339392a6c7605.
  - Idx 0 shows 2b7e151628aed2a6abf7158809cf4f3c.
  - The next cycle drops `po_key_valid`.
- Protocol corner cases:
  - `pi_load` during EXPAND -> ignored; K10 still appears 10 cycles after the first load.
  - `pi_load` and `pi_next_key` together in OUTPUT at idx 5 -> restart; `po_busy` = 1 and `po_key_valid` = 0 on the next cycle.
- Reset mid-operation: assert `pi_rst` at idx 4 -> outputs 0 immediately. A new load of the all-zero key yields a K10 that matches the reference model.
- With `INV_KEY_MIXCOL_EN`: idx 10 and idx 0 keys are unchanged; idx 1..9 keys equal InvMixColumns of the FIPS-197 round keys, checked against the software model.

Source files
------------

// File: rtl/inv_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inv_key_schedule                                                         |
// | AES-128 round keys in reverse order (K10..K0): forward-expands the       |
// | cipher key once, then walks back with the inverse key-schedule step.     |
// | Optional macro INV_KEY_MIXCOL_EN: InvMixColumns on keys of rounds 1..9.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inv_key_schedule (
  input  logic         pi_clk,
  input  logic         pi_rst,
  input  logic [127:0] pi_input_key,
  input  logic         pi_load,
  input  logic         pi_next_key,
  output logic [127:0] po_round_key,
  output logic [3:0]   po_round_idx,
  output logic         po_key_valid,
  output logic         po_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_key;
  logic [127:0] w_key_nxt;
  logic [3:0]   r_round;
  logic [3:0]   w_round_nxt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_g_in, w_g, w_rcon;
  logic [3:0]   w_rcon_idx;
  logic [127:0] w_fwd, w_inv;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // One shared 4-byte S-box: w3 going forward, w3^w2 (= previous w3) going back.
  assign w_g_in     = (r_state == S_OUTPUT) ? (w_w3 ^ w_w2) : w_w3;
  assign w_g        = sub_word({w_g_in[23:0], w_g_in[31:24]});
  assign w_rcon_idx = (r_state == S_EXPAND) ? (r_round + 4'd1) : r_round;
  assign w_rcon     = {rcon(w_rcon_idx), 24'h000000};

  assign w_n0  = w_w0 ^ w_g ^ w_rcon;
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign w_fwd = {w_n0, w_n1, w_n2, w_n3};
  assign w_inv = {w_w0 ^ w_g ^ w_rcon, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      r_state <= S_IDLE;
      r_key   <= 128'd0;
      r_round <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_round_nxt = r_round;
    case (r_state)
      S_IDLE: begin
        if (pi_load) begin
          w_key_nxt   = pi_input_key;
          w_round_nxt = 4'd0;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_key_nxt   = w_fwd;
        w_round_nxt = r_round + 4'd1;
        if (r_round == 4'd9) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (pi_load) begin
          w_key_nxt   = pi_input_key;
          w_round_nxt = 4'd0;
          w_state_nxt = S_EXPAND;
        end else if (pi_next_key) begin
          if (r_round != 4'd0) begin
            w_key_nxt   = w_inv;
            w_round_nxt = r_round - 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef INV_KEY_MIXCOL_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [127:0] w_mixed;
  assign w_mixed = {inv_mix_col(w_w0), inv_mix_col(w_w1), inv_mix_col(w_w2), inv_mix_col(w_w3)};
  // First and last round keys are used raw by the equivalent inverse cipher.
  assign po_round_key = ((r_round != 4'd0) && (r_round != 4'd10)) ? w_mixed : r_key;
`else
  assign po_round_key = r_key;
`endif

  assign po_round_idx = r_round;
  assign po_key_valid = (r_state == S_OUTPUT);
  assign po_busy      = (r_state == S_EXPAND);

endmodule
`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inv_key_schedule                                                      |
// | Directed scoreboard bench for inv_key_schedule (FIPS-197 key, protocol). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_inv_key_schedule;

  logic         pi_clk = 1'b0;
  logic         pi_rst = 1'b1;
  logic [127:0] pi_input_key = 128'd0;
  logic         pi_load = 1'b0;
  logic         pi_next_key = 1'b0;
  logic [127:0] po_round_key;
  logic [3:0]   po_round_idx;
  logic         po_key_valid;
  logic         po_busy;

  inv_key_schedule dut (
    .pi_clk       (pi_clk),
    .pi_rst       (pi_rst),
    .pi_input_key (pi_input_key),
    .pi_load      (pi_load),
    .pi_next_key  (pi_next_key),
    .po_round_key (po_round_key),
    .po_round_idx (po_round_idx),
    .po_key_valid (po_key_valid),
    .po_busy      (po_busy)
  );

  always #5 pi_clk = ~pi_clk;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cur = 0;
  int           nbusy;
  logic [7:0]   tb_sbox [256];
  logic [127:0] rk [11];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'd0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  // Reference S-box: brute-force inverse, bitwise affine equations.
  task automatic init_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
               inv[(i + 7) % 8] ^ c[i];
      tb_sbox[x] = s;
    end
  endtask

  task automatic build(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]], tb_sbox[t[31:24]]} ^
            {rc, 24'h0};
        rc = tb_mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] tb_invmix(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = k[127 - 32 * c - 8 * j -: 8];
      o[127 - 32 * c -: 8] = tb_mul(a[0], 8'h0e) ^ tb_mul(a[1], 8'h0b) ^ tb_mul(a[2], 8'h0d) ^ tb_mul(a[3], 8'h09);
      o[119 - 32 * c -: 8] = tb_mul(a[0], 8'h09) ^ tb_mul(a[1], 8'h0e) ^ tb_mul(a[2], 8'h0b) ^ tb_mul(a[3], 8'h0d);
      o[111 - 32 * c -: 8] = tb_mul(a[0], 8'h0d) ^ tb_mul(a[1], 8'h09) ^ tb_mul(a[2], 8'h0e) ^ tb_mul(a[3], 8'h0b);
      o[103 - 32 * c -: 8] = tb_mul(a[0], 8'h0b) ^ tb_mul(a[1], 8'h0d) ^ tb_mul(a[2], 8'h09) ^ tb_mul(a[3], 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] disp(input int i);
`ifdef INV_KEY_MIXCOL_EN
    if (i >= 1 && i <= 9) return tb_invmix(rk[i]);
`endif
    return rk[i];
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 128'(sb.size() > 0), 128'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 128'(po_key_valid), 128'd1);
      chk({tag, "_idx"}, 128'(po_round_idx), 128'(e.idx));
      chk({tag, "_key"}, po_round_key, e.key);
    end
  endtask

  task automatic step_next(input string tag);
    exp_t e;
    pi_next_key = 1'b1;
    e.idx = 4'(cur - 1);
    e.key = disp(cur - 1);
    sb.push_back(e);
    @(negedge pi_clk);
    cur--;
    sb_check(tag);
  endtask

  task automatic do_load(input string tag, input logic [127:0] k, input logic with_next,
                         input int glitch_at, output int busy_n);
    exp_t e;
    pi_input_key = k;
    pi_load      = 1'b1;
    pi_next_key  = with_next;
    build(k);
    e.idx = 4'd10;
    e.key = rk[10];
    sb.push_back(e);
    @(negedge pi_clk);
    pi_load     = 1'b0;
    pi_next_key = 1'b0;
    chk({tag, "_busy_after_load"}, 128'(po_busy), 128'd1);
    chk({tag, "_valid_after_load"}, 128'(po_key_valid), 128'd0);
    busy_n = 0;
    while (po_busy && busy_n < 40) begin
      busy_n++;
      pi_load      = (busy_n == glitch_at);
      pi_input_key = (busy_n == glitch_at) ? ~k : k;
      @(negedge pi_clk);
    end
    pi_load = 1'b0;
    chk({tag, "_busy_cycles"}, 128'(busy_n), 128'd10);
    cur = 10;
    sb_check({tag, "_k10"});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key"}, po_round_key, 128'd0);
    chk({tag, "_idx"}, 128'(po_round_idx), 128'd0);
    chk({tag, "_valid"}, 128'(po_key_valid), 128'd0);
    chk({tag, "_busy"}, 128'(po_busy), 128'd0);
  endtask

  initial begin
    init_sbox();

    // Reset with random inputs applied.
    pi_input_key = {$urandom, $urandom, $urandom, $urandom};
    pi_load      = 1'b1;
    pi_next_key  = 1'b1;
    repeat (3) @(negedge pi_clk);
    chk_zero("rst");
    pi_rst  = 1'b0;
    pi_load = 1'b0;
    repeat (3) @(negedge pi_clk);
    chk_zero("next_no_load");
    pi_next_key = 1'b0;

    // FIPS-197 vector, then walk down with next held high.
    do_load("fips", FIPS_K0, 1'b0, 0, nbusy);
    chk("fips_k10_const", po_round_key, FIPS_K10);
    for (int i = 9; i >= 0; i--) begin
      step_next("walk");
`ifndef INV_KEY_MIXCOL_EN
      if (cur == 9) chk("fips_k9_const", po_round_key, FIPS_K9);
      if (cur == 1) chk("fips_k1_const", po_round_key, FIPS_K1);
`endif
    end
    chk("fips_k0_const", po_round_key, FIPS_K0);
    @(negedge pi_clk);
    chk("past_k0_valid", 128'(po_key_valid), 128'd0);
    chk("past_k0_idx", 128'(po_round_idx), 128'd0);
    chk("past_k0_key", po_round_key, FIPS_K0);
    chk("past_k0_busy", 128'(po_busy), 128'd0);
    pi_next_key = 1'b0;

    // Load during EXPAND is ignored.
    do_load("glitch", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 3, nbusy);
    repeat (5) step_next("to_idx5");
    pi_next_key = 1'b0;

    // Load and next together at idx 5: load wins.
    do_load("restart", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, nbusy);
    repeat (6) step_next("to_idx4");
    pi_next_key = 1'b0;
    chk("at_idx4", 128'(po_round_idx), 128'd4);

    // Asynchronous reset mid-OUTPUT, then the all-zero key.
    #3 pi_rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge pi_clk);
    pi_rst = 1'b0;
    do_load("zero_key", 128'd0, 1'b0, 0, nbusy);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
